regfile_param: RTL
==================

# regfile_param

Parametrised general-purpose register file for the processor datapath: two registered read ports, one write port, and a per-register pending scoreboard for multicycle producers. On reset, a clear sequencer sweeps every entry to zero so storage can map to RAM without a parallel reset. Sits between decode (read/reserve) and writeback (write); the `ready` output holds the pipeline off until the sweep completes.

## Interface
- `DATA_W`, default 24: register width in bits.
- `ADDR_W`, default 5: register address width.
- `DEPTH`, default 32: number of registers; must be ≤ 2^ADDR_W and ≥ 2.
- `ZERO_REG`, default 1: when 1, register 0 always reads zero, ignores writes, and cannot be reserved.
- `clk`, in, 1: single clock; all state updates on its rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `read_addr1`, `read_addr2`, in, ADDR_W each: read port addresses.
- `read_data1`, `read_data2`, out, DATA_W each: registered read data.
- `pending1`, `pending2`, out, 1 each: registered scoreboard bit for the matching read address.
- `write_enable`, in, 1: write strobe.
- `write_addr`, in, ADDR_W: write address.
- `write_data`, in, DATA_W: write data.
- `reserve_en`, in, 1: marks `reserve_addr` as pending (result outstanding).
- `reserve_addr`, in, ADDR_W: register to reserve.
- `ready`, out, 1: high once the clear sweep has finished; low during reset and clear.

## Operation
- FSM states: CLEAR and RUN.
- `rst` high: state goes to CLEAR, sweep counter to 0, `ready` to 0, all read data and pending outputs to 0, and all pending bits to 0.
- CLEAR: each cycle writes 0 to entry[counter] and increments the counter. When the counter reaches DEPTH-1, that final write occurs and the state moves to RUN.
- While in CLEAR, `write_enable` and `reserve_en` are ignored, and all read data and pending outputs are driven 0.
- RUN: `ready` is 1.
  - Write: when `write_enable` is high and the address is valid, `entry[write_addr] <= write_data` and `pending[write_addr] <= 0`.
  - Reserve: when `reserve_en` is high, `pending[reserve_addr] <= 1`.
  - If a write and a reserve target the same address in the same cycle, the reserve wins: data is written and the pending bit ends at 1, representing a new producer.
- Address validity: an address ≥ DEPTH is out of range. Writes and reserves to it are dropped; reads from it return 0 with pending 0.
- `ZERO_REG` = 1: writes and reserves to address 0 are dropped, and reads of address 0 return 0 with pending 0.
- Both read ports are independent and may use the same address.
- `rst` asserted during RUN aborts all activity and restarts the sweep from entry 0.

## Timing
- Read latency is 1 cycle: addresses sampled at edge N produce data and pending valid after edge N.
- A write or reserve at edge N is visible to any read sampled at edge N+1 or later.
- Same-edge read and write to the same address: behaviour depends on `REGFILE_BYPASS_EN` (see Configuration).
- Clear sweep: `ready` rises DEPTH cycles after the first edge at which `rst` is sampled low. The default DEPTH of 32 gives 32 cycles.
- No combinational path from inputs to outputs.

## Configuration
- Macro `REGFILE_BYPASS_EN`, defined: write-through forwarding.
  - A read sampled at the same edge as a valid write to the same address returns `write_data`.
  - The pending bit returned on that read reflects the post-update value: 0, unless a same-address reserve is also active, in which case 1.
  - Same-edge reserve without a write is forwarded the same way.
- Macro `REGFILE_BYPASS_EN`, undefined: that read returns the pre-write contents and pending bit.
- Forwarding never applies in CLEAR, to out-of-range addresses, or to register 0 when `ZERO_REG` = 1.

## Structure
- Shared package `regfile_pkg` holds:
  - FSM state typedef (CLEAR, RUN);
  - default DATA_W, ADDR_W and DEPTH constants;
  - the reset data constant (all zero).
- Sub-module `regfile_scoreboard` holds:
  - the DEPTH-bit pending vector;
  - reserve/clear priority logic;
  - two registered lookups.
- Storage array, clear sequencer and read/bypass muxing live in the top module.

## Test plan
- Reset and clear:
  - Pulse `rst` for 1 cycle with DEPTH=32. `ready` must stay 0 for exactly 32 cycles, then go to 1.
  - During the sweep, `read_data1` must be 0 with `write_enable` held high.
  - After the sweep, every address must read 0.
- Basic write/read:
  - Write 0xABCDEF to register 5 at edge N, then read register 5 at N+1.
  - `read_data1` must equal 0xABCDEF one cycle later.
  - Writing 0x123456 to register 0 must leave register 0 reading 0.
- Bypass, run in both builds:
  - Write 0x00FF00 to register 7 while reading register 7 at the same edge.
  - With the macro defined, `read_data2` must be 0x00FF00; undefined, it must be the old value.
  - On the next read, 0x00FF00 must be returned in both builds.
- Scoreboard:
  - Reserve register 3, then read it: `pending1` must be 1.
  - Write 3 with 0x000042: pending must clear to 0.
  - Reserve and write register 3 at the same edge: data must be 0x000042 and pending must be 1.
- Reset mid-operation:
  - Write register 9 = 0x777777 and reserve register 9, then assert `rst` in RUN.
  - After `ready` rises again, register 9 must read 0 with pending 0.
- Out of range:
  - With DEPTH=24 and ADDR_W=5, write to address 30 and then read address 30.
  - Data and pending must be 0, and registers 0–23 must be unchanged.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and constants for the parametrised register file.
// Holds the CLEAR/RUN state encoding, the default geometry and the value the
// clear sequencer writes into every entry after reset.
package regfile_pkg;

  // Top-level sequencer states: sweeping storage to zero, or normal operation
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  // Default geometry: 32 registers of 24 bits, 5-bit addresses
  localparam int DEF_DATA_W = 24;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DEPTH  = 32;

  // Value written into every entry by the clear sweep
  localparam logic [DEF_DATA_W-1:0] RESET_DATA = '0;

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending bits for multicycle producers.
// A qualified write clears the bit, a qualified reserve sets it, and a reserve
// beats a write to the same register in the same cycle. Two registered lookups
// mirror the two read ports of the register file.
// Optional build macro: REGFILE_BYPASS_EN (lookups see the same-edge update).
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_go_i,
  input  logic [ADDR_W-1:0]      wr_addr_i,
  input  logic                   rsv_go_i,
  input  logic [ADDR_W-1:0]      rsv_addr_i,
  input  logic [1:0]             rd_ok_i,
  input  logic [1:0][ADDR_W-1:0] rd_addr_i,
  output logic [1:0]             pending_o
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0] pend_q;
  logic [DEPTH-1:0] pend_d;

  genvar gi;

  // Next-state per register: reserve has priority over a clearing write
  for (gi = 0; gi < DEPTH; gi++) begin : g_bit
    logic wr_hit;
    logic rsv_hit;
    assign wr_hit     = wr_go_i  && (wr_addr_i  == ADDR_W'(gi));
    assign rsv_hit    = rsv_go_i && (rsv_addr_i == ADDR_W'(gi));
    assign pend_d[gi] = rsv_hit ? 1'b1 : (wr_hit ? 1'b0 : pend_q[gi]);
  end

  // Pending vector register; reset clears every outstanding reservation
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  // Two registered lookups; an unqualified address reads back as not pending
  for (gi = 0; gi < 2; gi++) begin : g_look
    logic [IDX_W-1:0] idx;
    logic             look_d;
    logic             look_q;

    assign idx = rd_addr_i[gi][IDX_W-1:0];

`ifdef REGFILE_BYPASS_EN
    // Forward the post-update bit so a same-edge write/reserve is visible
    assign look_d = rd_ok_i[gi] ? pend_d[idx] : 1'b0;
`else
    // Report the bit as it stood before this edge's update
    assign look_d = rd_ok_i[gi] ? pend_q[idx] : 1'b0;
`endif

    // Lookup output register
    always_ff @(posedge clk) begin
      if (rst) begin
        look_q <= 1'b0;
      end else begin
        look_q <= look_d;
      end
    end

    assign pending_o[gi] = look_q;
  end

endmodule

// File: rtl/regfile_param.sv
// regfile_param: parametrised register file with two registered read ports,
// one write port and a pending scoreboard. After reset a sequencer sweeps
// every entry to zero, so storage needs no parallel reset; ready stays low
// until the sweep is done.
// Optional build macro: REGFILE_BYPASS_EN (write-through forwarding of a
// same-edge write/reserve to a read of the same register).
module regfile_param
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] read_addr1,
  input  logic [ADDR_W-1:0] read_addr2,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  output logic              pending1,
  output logic              pending2,
  input  logic              write_enable,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic              reserve_en,
  input  logic [ADDR_W-1:0] reserve_addr,
  output logic              ready
);

  localparam int                IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_LIM = (ADDR_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DEPTH - 1);

  // Address usable for storage: in range and not the hardwired zero register
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < DEPTH_LIM) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  state_e           state_q;
  logic [IDX_W-1:0] clr_cnt_q;
  logic             ready_q;

  logic             run_active;
  logic             clearing;
  logic             wr_go;
  logic             rsv_go;

  logic             mem_we;
  logic [IDX_W-1:0] mem_widx;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [1:0][ADDR_W-1:0] rd_addr;
  logic [1:0]             rd_ok;
  logic [1:0][DATA_W-1:0] rd_data;
  logic [1:0]             pend_out;

  // A reset cycle aborts any write/reserve even while the state still says RUN
  assign run_active = (state_q == ST_RUN) && !rst;
  assign clearing   = (state_q == ST_CLEAR) && !rst;
  assign wr_go      = run_active && write_enable && addr_ok(write_addr);
  assign rsv_go     = run_active && reserve_en && addr_ok(reserve_addr);

  // Clear sequencer: one entry per cycle, final write at DEPTH-1 enters RUN
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          if (clr_cnt_q == LAST_IDX) begin
            state_q <= ST_RUN;
            ready_q <= 1'b1;
          end else begin
            clr_cnt_q <= clr_cnt_q + IDX_W'(1);
          end
        end
        ST_RUN: begin
          ready_q <= 1'b1;
        end
        default: begin
          state_q   <= ST_CLEAR;
          clr_cnt_q <= '0;
          ready_q   <= 1'b0;
        end
      endcase
    end
  end

  assign ready = ready_q;

  // Single storage write port shared by the sweep and the datapath write
  assign mem_we    = clearing || wr_go;
  assign mem_widx  = clearing ? clr_cnt_q : write_addr[IDX_W-1:0];
  assign mem_wdata = clearing ? DATA_W'(RESET_DATA) : write_data;

  // Storage array, no reset so it can map onto block RAM
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_widx] <= mem_wdata;
    end
  end

  assign rd_addr[0] = read_addr1;
  assign rd_addr[1] = read_addr2;

`ifdef REGFILE_BYPASS_EN
  logic [DATA_W-1:0] byp_data_q;

  // Captured write data for ports that hit the same-edge write
  always_ff @(posedge clk) begin
    byp_data_q <= write_data;
  end
`endif

  genvar gi;

  for (gi = 0; gi < 2; gi++) begin : g_rd
    logic [DATA_W-1:0] mem_rd_q;
    logic              valid_q;

    assign rd_ok[gi] = run_active && addr_ok(rd_addr[gi]);

    // Storage read register (read-before-write on a same-address edge)
    always_ff @(posedge clk) begin
      mem_rd_q <= mem_q[rd_addr[gi][IDX_W-1:0]];
    end

    // Output qualifier: forces zero for reset, CLEAR, out-of-range and reg 0
    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
      end else begin
        valid_q <= rd_ok[gi];
      end
    end

`ifdef REGFILE_BYPASS_EN
    logic byp_q;

    // Remember whether this port's read coincided with a write to its address
    always_ff @(posedge clk) begin
      if (rst) begin
        byp_q <= 1'b0;
      end else begin
        byp_q <= rd_ok[gi] && wr_go && (write_addr == rd_addr[gi]);
      end
    end

    assign rd_data[gi] = !valid_q ? '0 : (byp_q ? byp_data_q : mem_rd_q);
`else
    assign rd_data[gi] = valid_q ? mem_rd_q : '0;
`endif
  end

  assign read_data1 = rd_data[0];
  assign read_data2 = rd_data[1];

  regfile_scoreboard #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .wr_go_i    (wr_go),
    .wr_addr_i  (write_addr),
    .rsv_go_i   (rsv_go),
    .rsv_addr_i (reserve_addr),
    .rd_ok_i    (rd_ok),
    .rd_addr_i  (rd_addr),
    .pending_o  (pend_out)
  );

  assign pending1 = pend_out[0];
  assign pending2 = pend_out[1];

endmodule
